cla_rr_arbiter: RTL and testbench
=================================

Name: cla_rr_arbiter

Overview:
- Round-robin arbiter that shares one pipelined 32-bit CLA adder (fixed latency LAT) among N requesters.
- Issues at most one operation per cycle to the adder.
- Carries requester IDs through a tag pipeline matched to the adder latency, so each result returns tagged with its owner.
- Sits between client blocks and the adder instance; contains no arithmetic itself.

Parameters:
- N, 4, number of requesters (2..8)
- IDW, 2, width of requester ID; must satisfy 2^IDW >= N
- LAT, 2, adder latency in clock edges from operand presentation to valid sum (1..8)
- CNTW, 16, width of the issued-operation counter

Ports:
- CLK  input  1  clock; all state on rising edge
- RESETn  input  1  asynchronous active-low reset
- hold  input  1  when 1, no new grants; in-flight operations still drain
- req_valid  input  N  per-requester request
- req_ready  output  N  one-hot grant; combinational
- req_A  input  N*32  packed operand A; requester i uses bits [32i+31:32i]
- req_B  input  N*32  packed operand B
- req_cin  input  N  per-requester carry-in
- add_A  output  32  registered operand A to adder
- add_B  output  32  registered operand B to adder
- add_cin  output  1  registered carry-in to adder
- add_sum  input  32  adder sum
- add_cout  input  1  adder carry-out
- rsp_valid  output  1  result valid this cycle
- rsp_id  output  IDW  ID of the requester owning the result
- rsp_sum  output  32  equals add_sum
- rsp_cout  output  1  equals add_cout
- issue_cnt  output  CNTW  count of accepted operations; wraps
- busy  output  1  1 while any tag stage is valid

Behaviour:
- Reset (RESETn=0, asynchronous): ptr=0; all tag stages invalid; add_A, add_B, add_cin = 0; rsp_valid=0, rsp_id=0; issue_cnt=0; busy=0.
- Arbitration (combinational):
  - If hold=1 or no req_valid is set, req_ready=0.
  - Otherwise req_ready is one-hot on the first i with req_valid[i]=1, scanning ptr, ptr+1, ... modulo N.
- Accept: a handshake is req_valid[i] & req_ready[i] at a rising edge E. At E:
  - add_A, add_B, add_cin <= requester i's operands.
  - Tag stage 0 <= {valid=1, id=i}.
  - ptr <= (i+1) mod N.
  - issue_cnt <= issue_cnt+1, wrapping from all-ones to 0.
- No accept at an edge: tag stage 0 <= invalid; add_* hold their previous values; ptr unchanged.
- Tag pipeline: LAT registered stages; stage k <= stage k-1 every edge; no stall.
- Response: rsp_valid and rsp_id come from the last stage. For an accept at E, rsp_valid=1 in the cycle after edge E+LAT-1, i.e. at the same time the adder presents that sum. rsp_sum and rsp_cout pass through add_sum/add_cout combinationally.
- Responses have no backpressure; clients must sink rsp every cycle.
- Throughput: one accept per cycle sustained; back-to-back results stay in accept order.
- busy = OR of all tag-stage valid bits.
- Requester behaviour: operands must be stable while req_valid=1 and not granted. A requester may drop req_valid without being granted.
- hold asserted mid-stream: grants stop at the next edge; queued results still emerge; ptr unchanged while holding.
- Single active requester: granted every cycle, whatever ptr is.
- Requester IDs >= N never appear on rsp_id.
- Reset mid-operation: all in-flight tags discarded; no rsp_valid for them after reset release; ptr restarts at 0.

Test Plan:
- Single op: reset, req_valid=0001, A0=30000, B0=50000, cin=0 -> grant at first edge; rsp_valid=1 with rsp_id=0, rsp_sum=80000, rsp_cout=0 exactly LAT cycles after the accept edge; issue_cnt=1.
- Fairness: all four req_valid held high for 8 cycles with distinct operands -> grant order 0,1,2,3,0,1,2,3; rsp_id follows the same order; each rsp_sum matches its requester's A+B+cin.
- Carry: A=32'hFFFFFFFF, B=1, cin=0 from requester 2 -> rsp_sum=0, rsp_cout=1, rsp_id=2; also A=0, B=0, cin=1 -> rsp_sum=1.
- Hold: with requests pending, assert hold for 3 cycles -> req_ready=0 during hold; busy falls after LAT cycles; after release, arbitration resumes from the saved ptr.
- Reset mid-stream: issue 2 ops, pull RESETn low before either returns -> no rsp_valid for them after release; issue_cnt=0; ptr=0, so requester 0 wins the first contested grant.
- Counter wrap: with CNTW=4, issue 17 ops -> issue_cnt=1.

Source files
------------

// File: rtl/cla_rr_arbiter.sv
// cla_rr_arbiter: round-robin front end for one shared, pipelined 32-bit CLA adder.
// N clients compete for the adder. At most one operation is issued per cycle.
// The owner's ID travels down a tag pipeline that is LAT stages deep, so each sum
// that comes back from the adder is labelled with the requester that issued it.
// This block does no arithmetic of its own.
//
// Ports
//   CLK, RESETn        clock (rising edge) and asynchronous active-low reset
//   hold               blocks new grants; operations already issued still drain
//   req_valid/ready    per-requester request, and the one-hot combinational grant
//   req_A/B/cin        packed per-requester operands (requester i uses slice i)
//   add_A/B/cin        registered operands presented to the adder
//   add_sum/cout       adder result, valid LAT edges after the operands
//   rsp_valid/id       result strobe and owning requester ID
//   rsp_sum/cout       adder result passed straight through
//   issue_cnt          number of accepted operations; wraps
//   busy               high while any tag stage holds an operation
module cla_rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned IDW  = 2,
  parameter int unsigned LAT  = 2,
  parameter int unsigned CNTW = 16
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              hold,
  input  logic [N-1:0]      req_valid,
  output logic [N-1:0]      req_ready,
  input  logic [N*32-1:0]   req_A,
  input  logic [N*32-1:0]   req_B,
  input  logic [N-1:0]      req_cin,
  output logic [31:0]       add_A,
  output logic [31:0]       add_B,
  output logic              add_cin,
  input  logic [31:0]       add_sum,
  input  logic              add_cout,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [31:0]       rsp_sum,
  output logic              rsp_cout,
  output logic [CNTW-1:0]   issue_cnt,
  output logic              busy
);

  localparam int unsigned DW = 32;
  // One extra bit, so that ptr + offset (which is below 2N) fits before it is reduced mod N.
  localparam int unsigned SW = IDW + 1;

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
  } tag_t;

  logic [IDW-1:0] ptr;
  logic [N-1:0]   req_rot;
  logic           gnt_any;
  logic [SW-1:0]  gnt_sum;
  logic [IDW-1:0] gnt_id;
  logic [IDW-1:0] ptr_nxt;
  logic           accept;
  logic [DW-1:0]  sel_A;
  logic [DW-1:0]  sel_B;
  logic           sel_cin;
  tag_t           tag_q [LAT];

  // Rotate the requests so that bit 0 is the requester at ptr. The lowest set bit wins.
  always_comb begin
    req_rot = N'({req_valid, req_valid} >> ptr);
    gnt_any = 1'b0;
    gnt_sum = '0;
    if (!hold) begin
      for (int k = 0; k < N; k++) begin
        if (!gnt_any && req_rot[k]) begin
          gnt_any = 1'b1;
          gnt_sum = SW'(ptr) + SW'(k);
        end
      end
    end
    if (gnt_sum >= SW'(N)) begin
      gnt_sum = gnt_sum - SW'(N);
    end
    gnt_id = gnt_sum[IDW-1:0];
  end

  // Drive the one-hot grant. The pointer moves to the slot just after the winner.
  always_comb begin
    req_ready = '0;
    if (gnt_any) begin
      req_ready = N'(1) << gnt_id;
    end
    accept  = |(req_valid & req_ready);
    ptr_nxt = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + IDW'(1);
  end

  // The grant is one-hot, so an AND-OR mux selects the winner's operands.
  always_comb begin
    sel_A   = '0;
    sel_B   = '0;
    sel_cin = 1'b0;
    for (int i = 0; i < N; i++) begin
      sel_A   = sel_A | ({DW{req_ready[i]}} & req_A[i*DW +: DW]);
      sel_B   = sel_B | ({DW{req_ready[i]}} & req_B[i*DW +: DW]);
      sel_cin = sel_cin | (req_ready[i] & req_cin[i]);
    end
  end

  // Round-robin pointer. It moves only on an accepted operation.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= ptr_nxt;
    end
  end

  // Operand registers that feed the adder. They keep their value when idle.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      add_A   <= '0;
      add_B   <= '0;
      add_cin <= 1'b0;
    end else if (accept) begin
      add_A   <= sel_A;
      add_B   <= sel_B;
      add_cin <= sel_cin;
    end
  end

  // Count of accepted operations; it wraps naturally.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      issue_cnt <= '0;
    end else if (accept) begin
      issue_cnt <= issue_cnt + CNTW'(1);
    end
  end

  // Tag pipeline. It has the same depth as the adder and never stalls.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int k = 0; k < LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      tag_q[0] <= accept ? '{valid: 1'b1, id: gnt_id} : '0;
      for (int k = 1; k < LAT; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  // Response side. The last tag stage lines up with the sum coming out of the adder.
  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      busy = busy | tag_q[k].valid;
    end
    rsp_valid = tag_q[LAT-1].valid;
    rsp_id    = tag_q[LAT-1].id;
    rsp_sum   = add_sum;
    rsp_cout  = add_cout;
  end

endmodule

// File: tb/tb_cla_rr_arbiter.sv
// Testbench for cla_rr_arbiter. It runs directed scenarios followed by random traffic.
// All outputs are compared with a reference model: a queue of expected responses
// plus a scan-based round-robin model.
module tb_cla_rr_arbiter;

  localparam int N    = 4;
  localparam int IDW  = 2;
  localparam int LAT  = 3;
  localparam int CNTW = 4;

  logic              CLK;
  logic              RESETn;
  logic              hold;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*32-1:0]   req_A;
  logic [N*32-1:0]   req_B;
  logic [N-1:0]      req_cin;
  logic [31:0]       add_A;
  logic [31:0]       add_B;
  logic              add_cin;
  logic [31:0]       add_sum;
  logic              add_cout;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [31:0]       rsp_sum;
  logic              rsp_cout;
  logic [CNTW-1:0]   issue_cnt;
  logic              busy;

  cla_rr_arbiter #(.N(N), .IDW(IDW), .LAT(LAT), .CNTW(CNTW)) dut (
    .CLK(CLK), .RESETn(RESETn), .hold(hold),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_A(req_A), .req_B(req_B), .req_cin(req_cin),
    .add_A(add_A), .add_B(add_B), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .issue_cnt(issue_cnt), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Adder stand-in. The operand register inside the DUT is one edge; LAT-1 more stages follow here.
  logic [32:0] apipe [LAT-1];
  always @(posedge CLK) begin
    apipe[0] <= {1'b0, add_A} + {1'b0, add_B} + 33'(add_cin);
    for (int k = 1; k < LAT - 1; k++) apipe[k] <= apipe[k-1];
  end
  assign add_sum  = apipe[LAT-2][31:0];
  assign add_cout = apipe[LAT-2][32];

  typedef struct {
    int          due;
    int          id;
    logic [31:0] sum;
    logic        cout;
  } exp_t;

  exp_t        expq[$];
  int          gnt_log[$];
  int          m_ptr;
  int          m_cnt;
  int          cyc;
  int          last_grant;
  int          vectors;
  int          miscompares;
  logic [31:0] opA [N];
  logic [31:0] opB [N];
  logic        opC [N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int ref_grant();
    if (hold) return -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_A[i*32 +: 32] = opA[i];
      req_B[i*32 +: 32] = opB[i];
      req_cin[i]        = opC[i];
    end
  endtask

  // Check the current cycle, step the model, then move to the next negedge.
  task automatic tick();
    int          g;
    int          obs;
    exp_t        e;
    logic [32:0] s;
    #1;
    g = ref_grant();
    check("req_ready", 64'(req_ready), (g >= 0) ? (64'(1) << g) : 64'(0));
    obs = -1;
    for (int i = 0; i < N; i++) if (req_ready[i]) obs = i;
    gnt_log.push_back(obs);
    check("busy", 64'(busy), 64'(expq.size() > 0));
    check("issue_cnt", 64'(issue_cnt), 64'(m_cnt));
    if (expq.size() > 0 && expq[0].due == cyc) begin
      e = expq.pop_front();
      check("rsp_valid", 64'(rsp_valid), 64'(1));
      check("rsp_id", 64'(rsp_id), 64'(e.id));
      check("rsp_sum", 64'(rsp_sum), 64'(e.sum));
      check("rsp_cout", 64'(rsp_cout), 64'(e.cout));
    end else begin
      check("rsp_valid", 64'(rsp_valid), 64'(0));
    end
    last_grant = -1;
    if (RESETn && g >= 0) begin
      s      = 33'(opA[g]) + 33'(opB[g]) + 33'(opC[g]);
      e.due  = cyc + LAT;
      e.id   = g;
      e.sum  = s[31:0];
      e.cout = s[32];
      expq.push_back(e);
      m_ptr      = (g + 1) % N;
      m_cnt      = (m_cnt + 1) % (1 << CNTW);
      last_grant = g;
    end
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESETn = 1'b0;
    expq.delete();
    m_ptr = 0;
    m_cnt = 0;
    tick();
    tick();
    RESETn = 1'b1;
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 3))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; m_ptr = 0; m_cnt = 0; last_grant = -1;
    hold = 1'b0; req_valid = '0; RESETn = 1'b0;
    for (int i = 0; i < N; i++) begin opA[i] = '0; opB[i] = '0; opC[i] = 1'b0; end
    apply();
    @(negedge CLK);
    do_reset();

    // Single operation from requester 0
    opA[0] = 32'd30000; opB[0] = 32'd50000; opC[0] = 1'b0; req_valid = 4'b0001; apply();
    tick();
    req_valid = '0;
    repeat (LAT + 1) tick();
    #1 check("single_cnt", 64'(issue_cnt), 64'(1));

    // Fairness: all four requesters contend, starting from ptr 0
    do_reset();
    gnt_log.delete();
    for (int i = 0; i < N; i++) begin opA[i] = 32'(1000 * (i + 1)); opB[i] = 32'(7 * i); opC[i] = 1'(i); end
    req_valid = '1; apply();
    for (int c = 0; c < 8; c++) begin
      tick();
      if (last_grant >= 0) begin
        opA[last_grant] = 32'(100000 + 13 * c);
        opB[last_grant] = 32'(last_grant * 5 + c);
        apply();
      end
    end
    for (int k = 0; k < 8; k++) check($sformatf("fair_order%0d", k), 64'(gnt_log[k]), 64'(k % 4));
    req_valid = '0;
    repeat (LAT + 1) tick();

    // Carry propagation through requester 2
    opA[2] = 32'hFFFF_FFFF; opB[2] = 32'd1; opC[2] = 1'b0; req_valid = 4'b0100; apply();
    tick();
    opA[2] = 32'h0; opB[2] = 32'h0; opC[2] = 1'b1; apply();
    tick();
    req_valid = '0;
    repeat (LAT + 1) tick();

    // Hold with requests pending: grants stop, the pipe drains, and arbitration resumes from ptr
    req_valid = '1; apply();
    repeat (2) tick();
    hold = 1'b1;
    repeat (LAT + 1) tick();
    #1 check("hold_busy", 64'(busy), 64'(0));
    hold = 1'b0;
    repeat (4) tick();
    req_valid = '0;
    repeat (LAT + 1) tick();

    // Reset while two operations are in flight
    req_valid = '1; apply();
    repeat (2) tick();
    do_reset();
    gnt_log.delete();
    tick();
    check("rst_first_gnt", 64'(gnt_log[0]), 64'(0));
    req_valid = '0;
    repeat (LAT + 1) tick();

    // Counter wrap with a single requester that is active every cycle
    do_reset();
    req_valid = 4'b0010;
    for (int c = 0; c < 17; c++) begin
      opA[1] = $urandom; opB[1] = $urandom; opC[1] = 1'($urandom_range(0, 1)); apply();
      tick();
    end
    req_valid = '0;
    #1 check("cnt_wrap", 64'(issue_cnt), 64'(1));
    repeat (LAT + 1) tick();

    // Random traffic. A requester keeps its operands stable until it is granted.
    repeat (2000) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || last_grant == i) begin
          opA[i] = rand_op(); opB[i] = rand_op(); opC[i] = 1'($urandom_range(0, 1));
          req_valid[i] = ($urandom_range(0, 2) != 0);
        end else if ($urandom_range(0, 9) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      hold = ($urandom_range(0, 7) == 0);
      apply();
      tick();
    end
    req_valid = '0; hold = 1'b0;
    repeat (LAT + 2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
